alu_result_stage: RTL and testbench

//  Pipeline register stage directly downstream of the combinational ALU in MY-P0.
//  - Captures the ALU result together with its operands, func code and destination tag.
//  - Derives condition flags and presents them to writeback/branch logic through a valid/ready handshake.
//  - A 2-entry skid buffer makes in_ready a pure register output, breaking the ready path.

---
 rtl/my_p0_pkg.sv | 33 +++
 rtl/alu_flag_gen.sv | 56 +++++
 rtl/alu_result_stage.sv | 107 ++++++++++
 tb/tb_alu_result_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_p0_pkg.sv
// Shared MY-P0 definitions: ALU func codes, datapath widths and the result-stage entry.
// The optional out_ovf feature is controlled by the ALU_RES_OVF_EN macro.
package my_p0_pkg;

  localparam int DATA_W = 32;
  localparam int DEST_W = 4;
  localparam int FUNC_W = 3;

  localparam logic [FUNC_W-1:0] FUNC_ADD   = 3'b000;
  localparam logic [FUNC_W-1:0] FUNC_SUB   = 3'b001;
  localparam logic [FUNC_W-1:0] FUNC_NAND  = 3'b010;
  localparam logic [FUNC_W-1:0] FUNC_INC   = 3'b011;
  localparam logic [FUNC_W-1:0] FUNC_PASSA = 3'b100;
  localparam logic [FUNC_W-1:0] FUNC_PASSB = 3'b101;
  localparam logic [FUNC_W-1:0] FUNC_ILL0  = 3'b110;
  localparam logic [FUNC_W-1:0] FUNC_ILL1  = 3'b111;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DEST_W-1:0] dest;
    logic              zero;
    logic              neg;
    logic              illegal;
`ifdef ALU_RES_OVF_EN
    logic              ovf;
`endif
  } res_entry_t;

  function automatic logic is_illegal_func(input logic [FUNC_W-1:0] func);
    return (func == FUNC_ILL0) || (func == FUNC_ILL1);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational capture-point logic: turns raw ALU inputs into a flagged result entry.
// Overflow detection is compiled in only with ALU_RES_OVF_EN.
module alu_flag_gen
  import my_p0_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [FUNC_W-1:0] func_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DEST_W-1:0] dest_i,
  output res_entry_t        entry_o
);

  logic              illegal;
  logic [DATA_W-1:0] result;

  assign illegal = is_illegal_func(func_i);
  // The ALU drives high-Z for illegal funcs, so never let that reach the register.
  assign result  = illegal ? '0 : result_i;

`ifdef ALU_RES_OVF_EN
  logic ovf;
  logic a_msb, b_msb, r_msb;

  assign a_msb = a_i[DATA_W-1];
  assign b_msb = b_i[DATA_W-1];
  assign r_msb = result[DATA_W-1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ovf = 1'b0;
    case (func_i)
      FUNC_ADD: ovf = (a_msb == b_msb) && (r_msb != a_msb);
      FUNC_SUB: ovf = (a_msb != b_msb) && (r_msb != a_msb);
      FUNC_INC: ovf = (a_i == {1'b0, {(DATA_W-1){1'b1}}});
      default:  ovf = 1'b0;
    endcase
  end
`else
  logic unused_operands;
  assign unused_operands = ^{a_i, b_i};
`endif

  always_comb begin
    entry_o         = '0;
    entry_o.result  = result;
    entry_o.dest    = dest_i;
    entry_o.zero    = (result == '0);
    entry_o.neg     = result[DATA_W-1];
    entry_o.illegal = illegal;
`ifdef ALU_RES_OVF_EN
    entry_o.ovf     = ovf;
`endif
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: 2-entry skid buffer with valid/ready on both sides.
// Define ALU_RES_OVF_EN to add the out_ovf port and signed-overflow flag.
module alu_result_stage #(
  parameter int DATA_W = my_p0_pkg::DATA_W,
  parameter int DEST_W = my_p0_pkg::DEST_W,
  parameter int FUNC_W = my_p0_pkg::FUNC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [FUNC_W-1:0] in_func,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_illegal
`ifdef ALU_RES_OVF_EN
  ,
  output logic              out_ovf
`endif
);

  import my_p0_pkg::*;

  res_entry_t cap_entry;
  res_entry_t main_q, main_d;
  res_entry_t skid_q, skid_d;
  logic       main_valid_q, main_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       in_ready_q;
  logic       accept, emit;

  alu_flag_gen u_flag_gen (
    .a_i      (in_a),
    .b_i      (in_b),
    .func_i   (in_func),
    .result_i (in_result),
    .dest_i   (in_dest),
    .entry_o  (cap_entry)
  );

  assign accept = in_valid & in_ready_q & ~flush;
  assign emit   = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (emit && skid_valid_q) begin
      // in_ready is low whenever skid is full, so no accept can collide here.
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!main_valid_q || emit)) begin
      main_d       = cap_entry;
      main_valid_d = 1'b1;
    end else if (accept) begin
      skid_d       = cap_entry;
      skid_valid_d = 1'b1;
    end else if (emit) begin
      main_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
    end
  end

  // NOTE: skid payload is left unreset; skid_valid_q alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_result  = main_q.result;
  assign out_dest    = main_q.dest;
  assign out_zero    = main_q.zero;
  assign out_neg     = main_q.neg;
  assign out_illegal = main_q.illegal;
`ifdef ALU_RES_OVF_EN
  assign out_ovf     = main_q.ovf;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: reference model pushes expectations on accept,
// a negedge monitor pops and compares on every emit. Works with or without ALU_RES_OVF_EN.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b, in_result;
  logic [2:0]  in_func;
  logic [3:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_dest;
  logic        out_zero, out_neg, out_illegal;
  logic        ovf_bit;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_func     (in_func),
    .in_result   (in_result),
    .in_dest     (in_dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_dest    (out_dest),
    .out_zero    (out_zero),
    .out_neg     (out_neg),
    .out_illegal (out_illegal)
`ifdef ALU_RES_OVF_EN
    ,
    .out_ovf     (ovf_bit)
`endif
  );

`ifndef ALU_RES_OVF_EN
  assign ovf_bit = 1'b0;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_emit   = 0;
  int          cyc      = 0;
  logic [39:0] exp_q[$];
  logic [39:0] cur_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU and flag model, written from the arithmetic meaning of each func.
  function automatic logic [31:0] alu_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return ~(a & b);
      3'd3:    return a + 32'd1;
      3'd4:    return a;
      3'd5:    return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [39:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b, input logic [3:0] d);
    longint      sa, sb, s;
    logic        illegal, ov;
    logic [31:0] r;
    sa      = longint'($signed(a));
    sb      = longint'($signed(b));
    illegal = (f >= 3'd6);
    r       = illegal ? 32'd0 : alu_ref(f, a, b);
    ov      = 1'b0;
`ifdef ALU_RES_OVF_EN
    case (f)
      3'd0:    begin s = sa + sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd1:    begin s = sa - sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd3:    begin s = sa + 1;  ov = (s > 64'sd2147483647); end
      default: ov = 1'b0;
    endcase
`endif
    return {r, d, (r == 32'd0), r[31], illegal, ov};
  endfunction

  function automatic logic [39:0] actual();
    return {out_result, out_dest, out_zero, out_neg, out_illegal, ovf_bit};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h0000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops an expectation whenever an emit will happen at the next edge.
  logic        prev_stall = 1'b0;
  logic [39:0] prev_val;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) check("hold_stable", 64'(actual()), 64'(prev_val));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_emit", 64'(out_valid), 64'd0);
        else                   check("emit_entry", 64'(actual()), 64'(exp_q.pop_front()));
        n_emit++;
      end
      prev_stall = out_valid && !out_ready;
      prev_val   = actual();
    end
  end

  task automatic set_input(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] d, input bit use_z);
    in_func = f;
    in_a    = a;
    in_b    = b;
    in_dest = d;
    if (f >= 3'd6) in_result = use_z ? 'z : $urandom;
    else           in_result = alu_ref(f, a, b);
    cur_exp = model(f, a, b, d);
  endtask

  task automatic tick();
    if (rst_n && in_valid && in_ready && !flush) exp_q.push_back(cur_exp);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_accept();
    bit acc = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) begin
      acc = in_ready && !flush;
      tick();
    end
    check("accept_within_bound", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] d, input bit use_z);
    set_input(f, a, b, d, use_z);
    wait_accept();
  endtask

  task automatic send_random();
    send(3'($urandom_range(7)), pick_operand(), pick_operand(), 4'($urandom), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  start_cyc, start_emit;
    bit  pending;
    bit  acc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_func = '0; in_result = '0; in_dest = '0; cur_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_outputs", 64'(actual()), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Flags and one-cycle latency
    out_ready = 1'b1;
    send(3'd0, 32'h7FFF_FFFF, 32'h1, 4'd3, 1'b0);
    check("add_latency", 64'(out_valid), 64'd1);
    check("add_neg", 64'(out_neg), 64'd1);
    check("add_zero", 64'(out_zero), 64'd0);
`ifdef ALU_RES_OVF_EN
    check("add_ovf", 64'(ovf_bit), 64'd1);
`endif
    send(3'd1, 32'd5, 32'd5, 4'd4, 1'b0);
    check("sub_zero", 64'(out_zero), 64'd1);
    check("sub_ovf", 64'(ovf_bit), 64'd0);
    tick();

    // Illegal func with floating ALU output
    send(3'b110, $urandom, $urandom, 4'd9, 1'b1);
    check("ill_result", 64'(out_result), 64'd0);
    check("ill_flags", 64'({out_zero, out_neg, out_illegal, ovf_bit}), 64'b1010);
    send(3'b111, 32'hFFFF_FFFF, 32'h8000_0000, 4'd10, 1'b0);
    tick();

    // Backpressure: third entry held upstream until out_ready rises
    out_ready = 1'b0;
    send(3'd4, 32'd1, 32'd0, 4'd1, 1'b0);
    check("bp_ready_after_1", 64'(in_ready), 64'd1);
    send(3'd4, 32'd2, 32'd0, 4'd2, 1'b0);
    check("bp_ready_after_2", 64'(in_ready), 64'd0);
    set_input(3'd4, 32'd3, 32'd0, 4'd3, 1'b0);
    in_valid = 1'b1;
    repeat (3) begin
      tick();
      check("bp_full_ready", 64'(in_ready), 64'd0);
      check("bp_out_first", 64'(out_result), 64'd1);
    end
    out_ready = 1'b1;
    wait_accept();
    repeat (4) tick();
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Streaming at one entry per cycle
    start_cyc  = cyc;
    start_emit = n_emit;
    for (int i = 0; i < 100; i++) send_random();
    check("stream_cycles", 64'(cyc - start_cyc), 64'd100);
    tick();
    check("stream_emits", 64'(n_emit - start_emit), 64'd100);

    // Flush with both entries full and input offered
    out_ready = 1'b0;
    send_random();
    send_random();
    set_input(3'd0, 32'd11, 32'd22, 4'd5, 1'b0);
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    exp_q.delete();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_full_valid", 64'(out_valid), 64'd0);
    check("flush_full_ready", 64'(in_ready), 64'd1);
    // Flush while ready: the offered entry must be dropped
    send_random();
    set_input(3'd5, 32'd0, 32'd77, 4'd6, 1'b0);
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    exp_q.delete();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_drop_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) tick();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send_random();
    send_random();
    set_input(3'd2, 32'hF0F0, 32'hFF00, 4'd7, 1'b0);
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) tick();
    check("rst_no_spurious", 64'(out_valid), 64'd0);

    // Random traffic with backpressure and occasional flush
    pending = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!pending && $urandom_range(9) < 7) begin
        set_input(3'($urandom_range(7)), pick_operand(), pick_operand(), 4'($urandom), 1'b0);
        pending = 1'b1;
      end
      in_valid  = pending;
      out_ready = ($urandom_range(9) < 6);
      flush     = ($urandom_range(49) == 0);
      acc       = in_valid && in_ready && !flush;
      tick();
      if (flush) begin
        exp_q.delete();
        flush = 1'b0;
      end
      if (acc) pending = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check("final_drained", 64'(exp_q.size()), 64'd0);
    check("final_idle", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
